// File: rtl/branch_stall_ctrl.sv
// ID-stage hazard-stall controller: branch/load-use stalls, taken-branch IF/ID flush.
// Optional perf counters are built when BRANCH_STALL_PERF_EN is defined.
module branch_stall_ctrl #(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Freeze,
    input  logic [1:0]        Branch,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic [4:0]        IF_ID_RegisterRs,
    input  logic [4:0]        IF_ID_RegisterRt,
    input  logic              ID_EX_RegWrite,
    input  logic              ID_EX_MemRead,
    input  logic [4:0]        ID_EX_RegisterRd,
    input  logic              EX_MEM_MemRead,
    input  logic [4:0]        EX_MEM_RegisterRd,
    input  logic              BranchTaken,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              ID_EX_Bubble,
    output logic              IF_ID_Flush,
    output logic [PERF_W-1:0] StallCnt,
    output logic [PERF_W-1:0] FlushCnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } stallState_e;

    stallState_e state;

    logic isBranch;
    logic matchEx;
    logic matchMem;
    logic hazTwo;
    logic hazOne;
    logic stall;

    // A source only matches when it is actually read and is not $0.
    always_comb begin
        isBranch = (Branch != 2'b00);
        matchEx  = (ID_EX_RegisterRd != 5'd0) &&
                   ((ID_UsesRs && (IF_ID_RegisterRs == ID_EX_RegisterRd)) ||
                    (ID_UsesRt && (IF_ID_RegisterRt == ID_EX_RegisterRd)));
        matchMem = (EX_MEM_RegisterRd != 5'd0) &&
                   ((ID_UsesRs && (IF_ID_RegisterRs == EX_MEM_RegisterRd)) ||
                    (ID_UsesRt && (IF_ID_RegisterRt == EX_MEM_RegisterRd)));
        hazTwo   = isBranch && ID_EX_MemRead && matchEx;
        hazOne   = (isBranch && ID_EX_RegWrite && matchEx && !ID_EX_MemRead) ||
                   (isBranch && EX_MEM_MemRead && matchMem) ||
                   (!isBranch && ID_EX_MemRead && matchEx);
    end

    always_comb begin
        stall        = !Freeze && ((state == HOLD) || hazTwo || hazOne);
        PCWrite      = !Freeze && !stall;
        IF_ID_Write  = !Freeze && !stall;
        ID_EX_Bubble = stall;
        IF_ID_Flush  = !Freeze && !stall && isBranch && BranchTaken;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else if (!Freeze) begin
            if (state == HOLD)
                state <= RUN;
            else if (hazTwo)
                state <= HOLD;
            else
                state <= RUN;
        end
    end

`ifdef BRANCH_STALL_PERF_EN
    logic [PERF_W-1:0] stallCntQ;
    logic [PERF_W-1:0] flushCntQ;

    // Both counters saturate; stall already excludes freeze cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (stall && (stallCntQ != '1))
                stallCntQ <= stallCntQ + 1'b1;
            if (IF_ID_Flush && (flushCntQ != '1))
                flushCntQ <= flushCntQ + 1'b1;
        end
    end

    assign StallCnt = stallCntQ;
    assign FlushCnt = flushCntQ;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Scoreboard bench for branch_stall_ctrl; counter checks follow BRANCH_STALL_PERF_EN.
module tb_branch_stall_ctrl;

    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Freeze;
    logic [1:0]    Branch;
    logic          ID_UsesRs, ID_UsesRt;
    logic [4:0]    IF_ID_RegisterRs, IF_ID_RegisterRt;
    logic          ID_EX_RegWrite, ID_EX_MemRead;
    logic [4:0]    ID_EX_RegisterRd;
    logic          EX_MEM_MemRead;
    logic [4:0]    EX_MEM_RegisterRd;
    logic          BranchTaken;
    logic          PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
    logic [PW-1:0] StallCnt, FlushCnt;

    branch_stall_ctrl #(.PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .Freeze(Freeze), .Branch(Branch),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_RegisterRd(ID_EX_RegisterRd), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_RegisterRd(EX_MEM_RegisterRd), .BranchTaken(BranchTaken),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .IF_ID_Flush(IF_ID_Flush), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    tag;
        logic [3:0] ctl;   // {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush}
    } expEntry_t;

    expEntry_t   sbQueue[$];
    int unsigned nAssert = 0;
    int unsigned nFail   = 0;
    int unsigned expStall = 0;
    int unsigned expFlush = 0;

    localparam logic [3:0] NORM  = 4'b1100;
    localparam logic [3:0] STALL = 4'b0010;
    localparam logic [3:0] FLUSH = 4'b1101;
    localparam logic [3:0] FRZ   = 4'b0000;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAssert++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned satInc(input int unsigned v);
        return (v >= (1 << PW) - 1) ? v : v + 1;
    endfunction

    task automatic clearIn();
        Freeze = 0; Branch = 2'b00; ID_UsesRs = 0; ID_UsesRt = 0;
        IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
        ID_EX_RegWrite = 0; ID_EX_MemRead = 0; ID_EX_RegisterRd = 0;
        EX_MEM_MemRead = 0; EX_MEM_RegisterRd = 0; BranchTaken = 0;
    endtask

    // Pop the oldest expectation and compare against current outputs.
    task automatic compareNow();
        expEntry_t e;
        if (sbQueue.size() == 0) begin
            checkEq("sbEmpty", 32'd1, 32'd0);
            return;
        end
        e = sbQueue.pop_front();
        checkEq({e.tag, ".ctl"}, {28'd0, PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush},
                {28'd0, e.ctl});
`ifdef BRANCH_STALL_PERF_EN
        checkEq({e.tag, ".stallCnt"}, 32'(StallCnt), expStall);
        checkEq({e.tag, ".flushCnt"}, 32'(FlushCnt), expFlush);
        if (e.ctl[1]) expStall = satInc(expStall);
        if (e.ctl[0]) expFlush = satInc(expFlush);
`else
        checkEq({e.tag, ".stallCnt"}, 32'(StallCnt), 32'd0);
        checkEq({e.tag, ".flushCnt"}, 32'(FlushCnt), 32'd0);
`endif
    endtask

    // Inputs are already driven; push expectation, sample at negedge, advance past posedge.
    task automatic step(input string tag, input logic [3:0] ctl);
        expEntry_t e;
        e.tag = tag;
        e.ctl = ctl;
        sbQueue.push_back(e);
        @(negedge clk);
        compareNow();
        @(posedge clk);
        #1;
    endtask

    task automatic loadBranch(input logic taken);
        clearIn();
        Branch = 2'b01; ID_UsesRs = 1; ID_UsesRt = 1;
        IF_ID_RegisterRs = 5'd1; IF_ID_RegisterRt = 5'd2;
        ID_EX_RegWrite = 1; ID_EX_MemRead = 1; ID_EX_RegisterRd = 5'd1;
        BranchTaken = taken;
    endtask

    initial begin
        expEntry_t e;
        clearIn();
        rst_n = 0;
        #2;
        e.tag = "reset"; e.ctl = NORM;
        sbQueue.push_back(e);
        compareNow();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // lw $1 ; beq $1,$2 -> two stall cycles
        loadBranch(1'b0);
        step("lwBeq.c1", STALL);
        step("lwBeq.c2hold", STALL);
        clearIn(); Branch = 2'b01;
        step("lwBeq.c3run", NORM);

        // add $3 ; bne $4,$3 -> one stall cycle
        clearIn();
        Branch = 2'b10; ID_UsesRs = 1; ID_UsesRt = 1;
        IF_ID_RegisterRs = 5'd4; IF_ID_RegisterRt = 5'd3;
        ID_EX_RegWrite = 1; ID_EX_RegisterRd = 5'd3;
        step("addBne.c1", STALL);
        ID_EX_RegWrite = 0; ID_EX_RegisterRd = 0; EX_MEM_RegisterRd = 5'd3;
        step("addBne.c2", NORM);

        // load in MEM with beq $5,$0
        clearIn();
        Branch = 2'b01; ID_UsesRs = 1; ID_UsesRt = 1;
        IF_ID_RegisterRs = 5'd5; IF_ID_RegisterRt = 5'd0;
        EX_MEM_MemRead = 1; EX_MEM_RegisterRd = 5'd5;
        step("memLoad.c1", STALL);
        EX_MEM_MemRead = 0;
        step("memLoad.c2", NORM);
        EX_MEM_MemRead = 1; EX_MEM_RegisterRd = 5'd0;
        step("memLoadR0", NORM);

        // load-use on non-branch, and unused source
        clearIn();
        ID_UsesRs = 1; IF_ID_RegisterRs = 5'd7;
        ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_RegisterRd = 5'd7;
        step("loadUse.c1", STALL);
        ID_UsesRs = 0;
        step("loadUseNoUses", NORM);

        // Rs == Rt == Rd: single stall
        clearIn();
        ID_UsesRs = 1; ID_UsesRt = 1;
        IF_ID_RegisterRs = 5'd9; IF_ID_RegisterRt = 5'd9;
        ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_RegisterRd = 5'd9;
        step("sameReg.c1", STALL);
        clearIn();
        step("sameReg.c2", NORM);

        // taken branch, no hazard
        clearIn(); Branch = 2'b01; BranchTaken = 1;
        step("takenBeq", FLUSH);
        clearIn();
        step("afterTaken", NORM);

        // taken branch during HOLD: flush only in the RUN cycle
        loadBranch(1'b1);
        step("takenHold.c1", STALL);
        step("takenHold.c2", STALL);
        clearIn(); Branch = 2'b11; BranchTaken = 1;
        step("takenHold.c3", FLUSH);

        // freeze while in HOLD
        loadBranch(1'b0);
        step("frzHold.enter", STALL);
        clearIn(); Freeze = 1;
        for (int i = 0; i < 3; i++) step("frzHold.frz", FRZ);
        Freeze = 0;
        step("frzHold.rel", STALL);
        step("frzHold.run", NORM);

        // freeze in RUN suppresses flush
        clearIn(); Freeze = 1; Branch = 2'b01; BranchTaken = 1;
        step("frzTaken", FRZ);

        // async reset mid-HOLD
        loadBranch(1'b0);
        step("rstHold.enter", STALL);
        clearIn();
        rst_n = 0;
        #1;
        expStall = 0; expFlush = 0;
        e.tag = "rstHold.async"; e.ctl = NORM;
        sbQueue.push_back(e);
        compareNow();
        #1;
        rst_n = 1;
        step("rstHold.after", NORM);

        // counter saturation
        clearIn();
        ID_UsesRs = 1; IF_ID_RegisterRs = 5'd6;
        ID_EX_MemRead = 1; ID_EX_RegisterRd = 5'd6;
        for (int i = 0; i < 18; i++) step("satStall", STALL);
        clearIn(); Branch = 2'b10; BranchTaken = 1;
        for (int i = 0; i < 18; i++) step("satFlush", FLUSH);
        clearIn();
        step("final", NORM);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
